// File: rtl/opt1_acc_drain_if.sv
// Handshake bundle between a PE carry-save drain and its consumer.
// Widths must match the opt1_acc_drain instance it connects to.
interface opt1_acc_drain_if #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16
);
  logic [ACC_WIDTH-1:0] acc_sum_in;
  logic [ACC_WIDTH-1:0] acc_carry_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_sat;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output acc_sum_in, acc_carry_in, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  acc_sum_in, acc_carry_in, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/opt1_acc_drain.sv
// Resolves a carry-save accumulator pair, shifts and narrows it (OPT1_ACC_SAT_EN clamps).
// Latency 3 cycles, one pair per cycle; stalls propagate back stage by stage to in_ready.
module opt1_acc_drain #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  opt1_acc_drain_if.slave   bus
);
  localparam int H = ACC_WIDTH / 2;

  logic                 s1_vld, s2_vld, s3_vld;
  logic                 s1_ld, s2_ld, s3_ld;
  logic [H-1:0]         s1_lo, s1_sum_hi, s1_carry_hi;
  logic                 s1_co;
  logic [ACC_WIDTH-1:0] s2_r;
  logic [OUT_WIDTH-1:0] s3_dat, nxt_dat;
  logic [H:0]           lo_full;

  // Each stage may load when the one after it is empty or emptying this cycle.
  assign s3_ld        = !s3_vld || bus.out_ready;
  assign s2_ld        = !s2_vld || s3_ld;
  assign s1_ld        = !s1_vld || s2_ld;
  assign bus.in_ready = s1_ld;

  assign lo_full = {1'b0, bus.acc_sum_in[H-1:0]} + {1'b0, bus.acc_carry_in[H-1:0]};

  assign bus.out_valid = s3_vld;
  assign bus.out_data  = s3_dat;

`ifdef OPT1_ACC_SAT_EN
  logic signed [ACC_WIDTH-1:0]   v;
  logic [ACC_WIDTH-OUT_WIDTH:0]  v_top;
  logic                          ovf;
  logic                          s3_sat;

  assign v     = $signed(s2_r) >>> SHIFT;
  // Fits in OUT_WIDTH only if every bit from the output sign bit upward agrees.
  assign v_top = v[ACC_WIDTH-1:OUT_WIDTH-1];
  assign ovf   = !((&v_top) || !(|v_top));

  always_comb begin
    nxt_dat = v[OUT_WIDTH-1:0];
    if (ovf) begin
      nxt_dat = v[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                               : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_sat <= 1'b0;
    end else if (s3_ld && s2_vld) begin
      s3_sat <= ovf;
    end
  end

  assign bus.out_sat = s3_sat;
`else
  assign nxt_dat     = OUT_WIDTH'($signed(s2_r) >>> SHIFT);
  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s2_vld      <= 1'b0;
      s3_vld      <= 1'b0;
      s1_lo       <= '0;
      s1_co       <= 1'b0;
      s1_sum_hi   <= '0;
      s1_carry_hi <= '0;
      s2_r        <= '0;
      s3_dat      <= '0;
    end else begin
      if (s1_ld) begin
        s1_vld <= bus.in_valid;
        if (bus.in_valid) begin
          s1_lo       <= lo_full[H-1:0];
          s1_co       <= lo_full[H];
          s1_sum_hi   <= bus.acc_sum_in[ACC_WIDTH-1:H];
          s1_carry_hi <= bus.acc_carry_in[ACC_WIDTH-1:H];
        end
      end
      if (s2_ld) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_r <= {s1_sum_hi + s1_carry_hi + {{(H-1){1'b0}}, s1_co}, s1_lo};
        end
      end
      if (s3_ld) begin
        s3_vld <= s2_vld;
        if (s2_vld) begin
          s3_dat <= nxt_dat;
        end
      end
    end
  end
endmodule

// File: doc/opt1_acc_drain.md
OPT1_ACC_DRAIN -- requirements
Module: opt1_acc_drain

Interface
REQ-001 Parameter ACC_WIDTH, default 32: width of the carry-save accumulator pair from the PE; even, ≥16.
REQ-002 Parameter OUT_WIDTH, default 16: width of the resolved output word; 2 ≤ OUT_WIDTH ≤ ACC_WIDTH.
REQ-003 Parameter SHIFT, default 0: arithmetic right-shift applied before narrowing; 0 ≤ SHIFT < ACC_WIDTH.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 acc_sum_in  input  ACC_WIDTH  PE carry-save sum vector.
REQ-007 acc_carry_in  input  ACC_WIDTH  PE carry-save carry vector.
REQ-008 in_valid  input  1  sum/carry pair valid this cycle.
REQ-009 in_ready  output  1  block accepts the pair this cycle.
REQ-010 out_data  output  OUT_WIDTH  resolved, shifted, narrowed result (two's complement).
REQ-011 out_sat  output  1  result was clamped (always 0 without saturation).
REQ-012 out_valid  output  1  out_data/out_sat valid.
REQ-013 out_ready  input  1  consumer accepts the output word.

Function
REQ-014 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-015 Three registered stages S1, S2, S3, each with its own valid bit; S3 drives the outputs.
REQ-016 S1: lower half sum_lo = sum[ACC_WIDTH/2-1:0] + carry[ACC_WIDTH/2-1:0]; registers its result, the carry-out bit, and the upper halves of both inputs.
REQ-017 S2: upper half sum + carry + S1 carry-out; registers the full resolved value R = (acc_sum_in + acc_carry_in) mod 2^ACC_WIDTH, interpreted as signed.
REQ-018 S3: registers V = R >>> SHIFT (sign-filling), narrowed per REQ-029/030.
REQ-019 Latency: output available with out_valid=1 exactly 3 cycles after acceptance when out_ready is held 1.
REQ-020 Throughput: one pair per cycle with out_ready held 1.
REQ-021 Stage Sk loads when Sk+1 is empty or transferring in the same cycle; otherwise it holds its contents.
REQ-022 S3 clears out_valid on transfer out unless S2 loads it in the same cycle.
REQ-023 in_ready = !S1.valid || S1 advancing; combinational from out_ready permitted.
REQ-024 No beat dropped, duplicated or reordered under any out_ready pattern.
REQ-025 out_data and out_sat held stable while out_valid=1 and out_ready=0.
REQ-026 Simultaneous in-transfer and out-transfer in one cycle fully supported at full occupancy.

Reset
REQ-027 rst=1 clears S1/S2/S3 valid bits, out_valid=0, out_data=0, out_sat=0, in_ready=1 in the cycle after release (combinational value 1 while all stages empty).
REQ-028 Reset asserted mid-operation discards all in-flight beats; no output appears after release until new input is accepted.

Configuration
REQ-029 Macro OPT1_ACC_SAT_EN defined: V is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; out_sat=1 when clamping occurred.
REQ-030 OPT1_ACC_SAT_EN undefined: out_data = V[OUT_WIDTH-1:0] (wrap); out_sat tied 0; no clamp logic synthesized.

Verification
REQ-031 ACC_WIDTH=32, OUT_WIDTH=16, SHIFT=0; sum=0xFFFFFFF0, carry=0x00000005, out_ready=1 -> 3 cycles later out_data=0xFFF5, out_sat=0.
REQ-032 SHIFT=4; sum=0x0000FFFF, carry=0x00000001 (carry across halves) -> out_data=0x1000, out_sat=0.
REQ-033 sum=0x00007000, carry=0x00002000 -> with OPT1_ACC_SAT_EN out_data=0x7FFF, out_sat=1; without it out_data=0x9000, out_sat=0.
REQ-034 out_ready=0 for 6 cycles, in_valid=1 with values 1..5 -> exactly 3 accepted, in_ready=0 afterwards; on out_ready=1 outputs 1,2,3,4,5 emerge in order, one per cycle, none lost.
REQ-035 Stream 10 beats with random out_ready toggling -> 10 outputs, order and values matching a reference model.
REQ-036 rst pulsed while 2 beats are in flight -> out_valid=0 next cycle; no stale output after release; next accepted beat emerges 3 cycles later.
